// File: rtl/phase_sequencer_pkg.sv
// Shared phase/state definitions for the instruction phase sequencer and its consumers.
// The control unit uses PH_LAST for its register/memory write strobe.
package phase_sequencer_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FIRST = 3'd1;
    localparam logic [2:0] PH_LAST  = 3'd5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StHalted = 2'd3
    } seq_state_e;

    // LED decode: bit i set when ph == i; out-of-range values light nothing
    function automatic logic [5:0] phase_onehot(input logic [2:0] ph);
        logic [5:0] oh;
        for (int i = 0; i < 6; i++) begin
            oh[i] = (ph == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/phase_sequencer_btn_pulse.sv
// Front-panel button conditioner: 2-FF synchroniser followed by a rising-edge detector.
// Emits one clk-cycle pulse per press regardless of how long the button is held.
module phase_sequencer_btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps phases 1..PH_LAST per instruction with run/stop/step
// control from the front panel, halts on the control unit's hlt flag, counts retired instructions.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             hlt,
    output logic [2:0]       phase,
    output logic [5:0]       phase_oh,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    logic start_p, stop_p, step_p;

    phase_sequencer_btn_pulse u_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (start),
        .pulse (start_p)
    );

    phase_sequencer_btn_pulse u_stop (
        .clk   (clk),
        .rst   (rst),
        .btn   (stop),
        .pulse (stop_p)
    );

    phase_sequencer_btn_pulse u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (step),
        .pulse (step_p)
    );

    seq_state_e       state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic             stop_req_q, stop_req_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= PH_IDLE;
            stop_req_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            stop_req_q <= stop_req_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        stop_req_d = stop_req_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                phase_d    = PH_IDLE;
                stop_req_d = 1'b0;
                if (start_p && !stop_p) begin
                    state_d = StRun;
                    phase_d = PH_FIRST;
                end else if (step_p && !start_p) begin
                    state_d = StStep;
                    phase_d = PH_FIRST;
                end
            end
            StRun, StStep: begin
                if (phase_q == PH_LAST) begin
                    // instruction boundary: retire, then halt > stop/step-end > continue
                    count_d    = count_q + CNT_W'(1);
                    stop_req_d = 1'b0;
                    if (hlt) begin
                        state_d = StHalted;
                        phase_d = PH_IDLE;
                    end else if (stop_req_q || (stop_p && state_q == StRun)
                                 || state_q == StStep) begin
                        state_d = StIdle;
                        phase_d = PH_IDLE;
                    end else begin
                        phase_d = PH_FIRST;
                    end
                end else if (phase_q >= PH_FIRST && phase_q < PH_LAST) begin
                    phase_d = phase_q + 3'd1;
                    if (state_q == StRun && stop_p) begin
                        stop_req_d = 1'b1;
                    end
                end else begin
                    // phase 0 or out of range while executing: recover to idle
                    state_d    = StIdle;
                    phase_d    = PH_IDLE;
                    stop_req_d = 1'b0;
                end
            end
            StHalted: begin
                phase_d    = PH_IDLE;
                stop_req_d = 1'b0;
            end
            default: begin
                state_d    = StIdle;
                phase_d    = PH_IDLE;
                stop_req_d = 1'b0;
            end
        endcase
    end

    assign phase       = phase_q;
    assign phase_oh    = phase_onehot(phase_q);
    assign running     = (state_q == StRun) || (state_q == StStep);
    assign halted      = (state_q == StHalted);
    assign instr_count = count_q;

endmodule
